// File: rtl/iq_ddc_cic.sv
// iq_ddc_cic -- quadrature down-converter with 3-stage CIC decimation.
//
// Mixes each signed ADC sample with the NCO cos/sin pair. It then
// decimates the I and Q rails by R = 2**DECIM_LOG2 through a
// 3-integrator / 3-comb CIC filter with a differential delay of 1.
//
// Ports:
//   clk            clock, rising edge
//   arst           synchronous active-high reset
//   sample_clk_ce  sample enable (same strobe as the NCO)
//   adc_sample     signed ADC sample, valid with sample_clk_ce
//   sinewave       signed NCO sine   (Q rail, Q = +x*sin)
//   cosinewave     signed NCO cosine (I rail)
//   i_out / q_out  signed decimated I/Q, held between strobes
//   out_valid      one-clk strobe marking a new i_out/q_out
//
// Build option: define IQ_DDC_ROUND_EN for round-half-up with
// positive saturation. This adds one clk of latency (out_valid at
// E+4 instead of E+3). With the macro undefined, the output is a
// plain truncation (floor) of the top OUT_WIDTH bits.

// One rail (mixer + integrators + combs). The decimation counter and
// the strobe pipeline are shared and live in the top.
module iq_ddc_cic_rail #(
  parameter int ADC_WIDTH  = 8,
  parameter int SINE_WIDTH = 7,
  parameter int PROD_WIDTH = 15,
  parameter int ACC_WIDTH  = 21,
  parameter int OUT_WIDTH  = 14,
  parameter int STAGES     = 3
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         ce,
  input  logic                         win_end,
  input  logic [STAGES-1:0]            stb,
  input  logic signed [ADC_WIDTH-1:0]  adc,
  input  logic signed [SINE_WIDTH-1:0] lo,
  output logic signed [OUT_WIDTH-1:0]  y
);
  logic signed [PROD_WIDTH-1:0] mix;
  logic signed [ACC_WIDTH-1:0]  mix_ext;
  logic signed [ACC_WIDTH-1:0]  int1, int2, int3, snap;
  logic signed [ACC_WIDTH-1:0]  d0, d1, d2, c1, c2, c3_nxt;

  assign mix_ext = {{(ACC_WIDTH-PROD_WIDTH){mix[PROD_WIDTH-1]}}, mix};
  assign c3_nxt  = c2 - d2;

  // Integrators wrap modulo 2**ACC_WIDTH. The combs undo the wrap
  // because the true output always fits in ACC_WIDTH bits.
  always_ff @(posedge clk) begin
    if (arst) begin
      mix  <= '0;
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      snap <= '0;
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      c1   <= '0;
      c2   <= '0;
    end else begin
      if (ce) begin
        mix  <= adc * lo;
        int1 <= int1 + mix_ext;
        int2 <= int2 + int1;
        int3 <= int3 + int2;
      end
      // Take int3 as it was before the window-end edge.
      if (win_end) snap <= int3;
      // Each comb stage advances only on its own strobe bit, so ce gaps
      // after the window end do not stall the comb chain.
      if (stb[0]) begin
        c1 <= snap - d0;
        d0 <= snap;
      end
      if (stb[1]) begin
        c2 <= c1 - d1;
        d1 <= c1;
      end
      if (stb[2]) d2 <= c2;
    end
  end

`ifdef IQ_DDC_ROUND_EN
  logic signed [ACC_WIDTH-1:0] c3;
  logic signed [OUT_WIDTH-1:0] y_rnd;

  if (ACC_WIDTH == OUT_WIDTH) begin : g_pass
    assign y_rnd = c3;
  end else begin : g_rnd
    localparam logic [ACC_WIDTH:0] HALF =
      (ACC_WIDTH+1)'(1) << (ACC_WIDTH - OUT_WIDTH - 1);
    logic [ACC_WIDTH:0] sum;
    // The adder is one bit wider than c3. A non-negative c3 whose sum
    // reaches the sign bit has overflowed, so it clamps to +max.
    assign sum   = {c3[ACC_WIDTH-1], c3} + HALF;
    assign y_rnd = (!c3[ACC_WIDTH-1] && sum[ACC_WIDTH-1]) ?
                   {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                   sum[ACC_WIDTH-1 -: OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      c3 <= '0;
      y  <= '0;
    end else begin
      if (stb[2]) c3 <= c3_nxt;
      if (stb[3]) y  <= y_rnd;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (arst)        y <= '0;
    else if (stb[2]) y <= c3_nxt[ACC_WIDTH-1 -: OUT_WIDTH];
  end
`endif
endmodule

module iq_ddc_cic #(
  parameter int ADC_WIDTH  = 8,
  parameter int SINE_WIDTH = 7,
  parameter int DECIM_LOG2 = 2,
  parameter int OUT_WIDTH  = 14
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         sample_clk_ce,
  input  logic signed [ADC_WIDTH-1:0]  adc_sample,
  input  logic signed [SINE_WIDTH-1:0] sinewave,
  input  logic signed [SINE_WIDTH-1:0] cosinewave,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic                         out_valid
);
  localparam int PROD_WIDTH = ADC_WIDTH + SINE_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + 3 * DECIM_LOG2;
  localparam int NUM_LANES  = 2;  // lane 0 = I (cos), lane 1 = Q (sin)
`ifdef IQ_DDC_ROUND_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  logic [DECIM_LOG2-1:0]                 dcnt;
  logic                                  win_end;
  logic [STAGES:0]                       vld_pipe;
  logic [NUM_LANES-1:0][SINE_WIDTH-1:0]  lo;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   y;

  // The window-end edge is the ce that occurs when the counter is R-1.
  assign win_end = sample_clk_ce & (&dcnt);

  // vld_pipe[0] fires comb 1, [1] fires comb 2, [2] fires comb 3, and
  // in the round build [3] loads the rounded output. The top bit is
  // out_valid.
  always_ff @(posedge clk) begin
    if (arst) begin
      dcnt     <= '0;
      vld_pipe <= '0;
    end else begin
      if (sample_clk_ce) dcnt <= dcnt + 1'b1;
      vld_pipe <= {vld_pipe[STAGES-1:0], win_end};
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign lo        = {sinewave, cosinewave};
  assign i_out     = y[0];
  assign q_out     = y[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    iq_ddc_cic_rail #(
      .ADC_WIDTH (ADC_WIDTH),
      .SINE_WIDTH(SINE_WIDTH),
      .PROD_WIDTH(PROD_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .STAGES    (STAGES)
    ) u_rail (
      .clk    (clk),
      .arst   (arst),
      .ce     (sample_clk_ce),
      .win_end(win_end),
      .stb    (vld_pipe[STAGES-1:0]),
      .adc    (adc_sample),
      .lo     (lo[g]),
      .y      (y[g])
    );
  end
endmodule

// File: tb/tb_iq_ddc_cic.sv
// Bench for iq_ddc_cic at default parameters (R=4, 7 bits dropped).
// Reference: the CIC output is the convolution of the mixer products
// with h = boxcar(R)*boxcar(R)*boxcar(R). There are 3 samples of
// pipeline delay, and the result is sampled once per window.
module tb_iq_ddc_cic;
  localparam int  R    = 4;
  localparam int  ACC  = 21;
  localparam int  DROP = 7;
  localparam int  HLEN = 3 * R - 2;
  localparam int  MAXO = 8191;
`ifdef IQ_DDC_ROUND_EN
  localparam int  LAT  = 4;
  localparam bit  RND  = 1'b1;
`else
  localparam int  LAT  = 3;
  localparam bit  RND  = 1'b0;
`endif

  typedef struct { int due; int m; } exp_t;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              sample_clk_ce = 1'b0;
  logic signed [7:0] adc_sample = '0;
  logic signed [6:0] sinewave = '0;
  logic signed [6:0] cosinewave = '0;
  logic signed [13:0] i_out, q_out;
  logic              out_valid;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     cecnt = 0;
  longint h [HLEN];
  longint p_i [$];
  longint p_q [$];
  exp_t   exp_q [$];

  iq_ddc_cic dut (
    .clk          (clk),
    .arst         (arst),
    .sample_clk_ce(sample_clk_ce),
    .adc_sample   (adc_sample),
    .sinewave     (sinewave),
    .cosinewave   (cosinewave),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns the unscaled CIC output for window m on one rail.
  function automatic longint cic_y(input bit q, input int m);
    longint acc = 0;
    int n = m * R + R - 2;
    for (int j = 0; j < HLEN; j++) begin
      int k = n - 3 - j;
      if (k >= 0 && k < p_i.size())
        acc += h[j] * (q ? p_q[k] : p_i[k]);
    end
    return acc;
  endfunction

  function automatic int scale(input longint y);
    longint w;
    longint r;
    w = y & ((64'sd1 <<< ACC) - 1);
    if (w >= (64'sd1 <<< (ACC - 1))) w -= (64'sd1 <<< ACC);
    if (RND) begin
      r = (w + (64'sd1 <<< (DROP - 1))) >>> DROP;
      if (r > MAXO) r = MAXO;
    end else begin
      r = w >>> DROP;
    end
    return int'(r);
  endfunction

  task automatic step(input bit ce, input bit rst, input int a, input int s, input int c);
    bit   ev;
    exp_t e;
    arst          = rst;
    sample_clk_ce = ce;
    adc_sample    = 8'(a);
    sinewave      = 7'(s);
    cosinewave    = 7'(c);
    @(posedge clk);
    cyc++;
    if (rst) begin
      p_i.delete();
      p_q.delete();
      exp_q.delete();
      cecnt = 0;
    end else if (ce) begin
      p_i.push_back(longint'(a) * longint'(c));
      p_q.push_back(longint'(a) * longint'(s));
      if (cecnt % R == R - 1) exp_q.push_back('{due: cyc + LAT, m: cecnt / R});
      cecnt++;
    end
    #1;
    if (rst) begin
      chk("rst_i_out", int'(i_out), 0);
      chk("rst_q_out", int'(q_out), 0);
    end
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      e = exp_q.pop_front();
      chk("i_out", int'(i_out), scale(cic_y(1'b0, e.m)));
      chk("q_out", int'(q_out), scale(cic_y(1'b1, e.m)));
    end
  endtask

  initial begin
    longint tmp [HLEN];
    int     len;
    int     a, s, c;
    int     held_i, held_q;

    // h = boxcar(R) convolved three times
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len  = 1;
    repeat (3) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i + j] += h[i];
      len += R - 1;
      h = tmp;
    end

    // Reset state
    repeat (2) step(1'b0, 1'b1, 0, 0, 0);

    // DC mix, continuous ce
    repeat (40) step(1'b1, 1'b0, 100, 0, 63);
    repeat (5)  step(1'b0, 1'b0, 100, 0, 63);
    chk("dc_i", int'(i_out), 3150);
    chk("dc_q", int'(q_out), 0);

    // Same stimulus, ce every 3rd clk
    repeat (40) begin
      step(1'b1, 1'b0, 100, 0, 63);
      repeat (2) step(1'b0, 1'b0, 100, 0, 63);
    end
    repeat (5) step(1'b0, 1'b0, 100, 0, 63);
    chk("gap_i", int'(i_out), 3150);
    chk("gap_q", int'(q_out), 0);

    // Held outputs with ce stopped
    held_i = int'(i_out);
    held_q = int'(q_out);
    repeat (20) step(1'b0, 1'b0, -5, 9, -7);
    chk("held_i", int'(i_out), held_i);
    chk("held_q", int'(q_out), held_q);

    // Integrator wrap-around over a long run
    repeat (20000) step(1'b1, 1'b0, -128, 63, -63);
    repeat (5) step(1'b0, 1'b0, -128, 63, -63);
    chk("wrap_i", int'(i_out), 4032);
    chk("wrap_q", int'(q_out), -4032);

    // Output LSB boundary: +64 and -64 before scaling
    repeat (40) step(1'b1, 1'b0, 1, 0, 1);
    repeat (5)  step(1'b0, 1'b0, 1, 0, 1);
    chk("lsb_pos_i", int'(i_out), RND ? 1 : 0);
    repeat (40) step(1'b1, 1'b0, -1, 0, 1);
    repeat (5)  step(1'b0, 1'b0, -1, 0, 1);
    chk("lsb_neg_i", int'(i_out), RND ? 0 : -1);

    // Reset mid-window, with ce high during the reset (arst wins)
    step(1'b0, 1'b1, 0, 0, 0);
    repeat (2) step(1'b1, 1'b0, 100, 0, 63);
    step(1'b1, 1'b1, 100, 0, 63);
    chk("midrst_valid", int'(out_valid), 0);
    repeat (4) step(1'b1, 1'b0, 100, 0, 63);
    repeat (LAT + 2) step(1'b0, 1'b0, 100, 0, 63);
    chk("midrst_pending", exp_q.size(), 0);

    // Random samples with random ce gaps
    repeat (600) begin
      a = int'($urandom_range(0, 255)) - 128;
      s = int'($urandom_range(0, 127)) - 64;
      c = int'($urandom_range(0, 127)) - 64;
      step(1'($urandom_range(0, 1)), 1'b0, a, s, c);
    end
    repeat (LAT + 2) step(1'b0, 1'b0, 0, 0, 0);
    chk("rand_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iq_ddc_cic.md
# iq_ddc_cic

Quadrature digital down-converter stage consuming the NCO's `sinewave`/`cosinewave` outputs. On every sample-clock enable it mixes one signed ADC sample with the NCO pair to form I/Q products. It then decimates each rail with a 3-stage CIC filter (differential delay 1) by R = 2^DECIM_LOG2. Decimated I/Q words go out with a single-cycle valid strobe to the downstream baseband/demodulator logic.

## Interface
- `ADC_WIDTH`, 8, signed ADC sample width
- `SINE_WIDTH`, 7, signed NCO sine/cosine width (matches generator)
- `DECIM_LOG2`, 2, log2 of decimation ratio R; legal range 1..10
- `OUT_WIDTH`, 14, output width; must be ≤ ACC_WIDTH
- Derived: PROD_WIDTH = ADC_WIDTH+SINE_WIDTH; ACC_WIDTH = PROD_WIDTH + 3·DECIM_LOG2
- `clk`  in  1  clock; all logic on rising edge
- `arst`  in  1  reset, synchronous, active-high
- `sample_clk_ce`  in  1  sample enable, same strobe that drives the NCO
- `adc_sample`  in  ADC_WIDTH  signed input sample, valid when sample_clk_ce=1
- `sinewave`  in  SINE_WIDTH  signed NCO sine
- `cosinewave`  in  SINE_WIDTH  signed NCO cosine
- `i_out`  out  OUT_WIDTH  signed decimated in-phase
- `q_out`  out  OUT_WIDTH  signed decimated quadrature
- `out_valid`  out  1  one-clk strobe marking new i_out/q_out

## Operation
- Reset is synchronous: all registers clear to 0, including integrators, combs, decimation counter, i_out, q_out and out_valid. Reset mid-window discards the partial window. The first window after reset starts at the first ce.
- Mixer register, on ce: mix_i <= adc_sample·cosinewave, mix_q <= adc_sample·sinewave. Both are full PROD_WIDTH signed products. Sign convention Q = +x·sin.
- Integrators, on ce, per rail: int1 <= int1+mix; int2 <= int2+int1; int3 <= int3+int2. All are ACC_WIDTH-bit two's-complement. Wrap-around is required and must not be saturated.
- Decimation counter, on ce: counts 0..R-1 and wraps to 0. A ce edge with counter==R-1 is the window-end edge E.
- At E, per rail: snap <= int3 (the pre-E value); strobe pipeline bit s0 <= 1.
- Comb chain, each stage advancing only on its own strobe bit, each with its own delay register d: c1 <= snap−d0, d0 <= snap (at E+1); c2 <= c1−d1, d1 <= c1 (at E+2); c3 <= c2−d2, d2 <= c2 (at E+3).
- Output at E+3: i_out/q_out <= c3 scaled to OUT_WIDTH (see Configuration). out_valid <= 1 for exactly one clk.
- The comb pipeline is independent of ce. It keeps completing even if ce deasserts after E.
- DC gain is R³ (2^(3·DECIM_LOG2)). Output carries bits [ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH] of c3.
- The first 3 outputs after reset are CIC fill transients. Outputs are steady state from the 4th out_valid onward.

## Timing
- Latency from window-end ce edge E to out_valid high is 3 clks. out_valid is high in the cycle following edge E+3.
- Outputs hold between strobes. out_valid is never high for 2 consecutive clks.
- ce may be continuous or gapped. For R=2 with continuous ce, strobes are spaced 2 clks apart. The comb stages never collide because each stage fires once per strobe.
- ce and arst together: arst wins.

## Configuration
- `IQ_DDC_ROUND_EN` defined: add 2^(ACC_WIDTH−OUT_WIDTH−1) to c3 in an ACC_WIDTH+1 adder, then take the top bits, saturating to +max on positive overflow. This gives round-half-up with one added clk of latency (out_valid at E+4). If ACC_WIDTH==OUT_WIDTH, no add is performed but the extra stage remains.
- Undefined: plain truncation (floor) at E+3, no saturation logic.

## Test plan
Bench defaults: ADC 8, SINE 7, DECIM_LOG2 2 (R=4, gain 64), OUT 14, so 7 bits are dropped. Checks start from the 4th out_valid.
- DC mix: adc=100, cos=63, sin=0, ce every clk -> i_out=3150, q_out=0, out_valid every 4 clks, 3 clks after each window-end ce.
- Gapped ce (every 3rd clk), same stimulus -> identical values 3150/0, out_valid every 12 clks.
- Wrap-around: adc=−128, cos=−63, sin=63, run 20000 samples -> i_out=4032, q_out=−4032 throughout, despite integrator overflow.
- Rounding: adc=1, cos=1 -> truncate build i_out=0, IQ_DDC_ROUND_EN build i_out=1. adc=−1, cos=1 -> truncate −1, round 0. Round build shows out_valid at E+4.
- Reset mid-window: assert arst for 1 clk after 2 ces of a window -> next cycle all outputs 0. The next out_valid comes 3 clks after the 4th ce following reset.
- Held outputs: stop ce after a strobe -> i_out/q_out stable, no further out_valid.
